// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - bundle of program-memory, decoder and instruction-register signals for fetch_unit
//
// master : fetch_unit side (drives mem_addr/mem_rd, dec_opcode, ir_*, instr_count)
// slave  : environment side (drives mem_rdata, dec_size, ir_ready, redirect_*)
//
// Signals
//   mem_addr       16  program memory byte address
//   mem_rd          1  read strobe, mem_rdata valid one cycle later
//   mem_rdata       8  read data
//   dec_opcode      8  opcode presented to the combinational decoder
//   dec_size        2  instruction size (1..3, 0 treated as 1) for dec_opcode
//   ir_valid        1  assembled instruction available
//   ir_ready        1  downstream accepts the instruction
//   ir_opcode       8  opcode byte
//   ir_op1          8  first operand byte
//   ir_op2          8  second operand byte
//   ir_pc          16  address of ir_opcode
//   redirect_valid  1  jump/branch taken
//   redirect_pc    16  new fetch address
//   instr_count    16  accepted-instruction count
interface fetch_unit_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic [7:0]  dec_opcode;
   logic [1:0]  dec_size;
   logic        ir_valid;
   logic        ir_ready;
   logic [7:0]  ir_opcode;
   logic [7:0]  ir_op1;
   logic [7:0]  ir_op2;
   logic [15:0] ir_pc;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] instr_count;

   modport master (
      output mem_addr,
      output mem_rd,
      input  mem_rdata,
      output dec_opcode,
      input  dec_size,
      output ir_valid,
      input  ir_ready,
      output ir_opcode,
      output ir_op1,
      output ir_op2,
      output ir_pc,
      input  redirect_valid,
      input  redirect_pc,
      output instr_count
   );

   modport slave (
      input  mem_addr,
      input  mem_rd,
      output mem_rdata,
      input  dec_opcode,
      output dec_size,
      input  ir_valid,
      output ir_ready,
      input  ir_opcode,
      input  ir_op1,
      input  ir_op2,
      input  ir_pc,
      output redirect_valid,
      output redirect_pc,
      input  instr_count
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial instruction fetch and assembly unit
//
// Fetches a 1..3 byte instruction from byte-wide program memory, asks an
// external combinational decoder for its size, assembles opcode/operands and
// holds them on ir_* until the consumer accepts.
//
// Parameters
//   RESET_PC     address of the first opcode fetched after reset
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          fetch_unit_if.master (memory, decoder, instruction and redirect signals)
// Build option
//   FETCH_COUNT_EN  when defined, instr_count counts accepted instructions;
//                   otherwise instr_count is tied to zero.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  bus
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_OPC  = 3'd1;
   localparam logic [2:0] ST_DEC  = 3'd2;
   localparam logic [2:0] ST_B1   = 3'd3;
   localparam logic [2:0] ST_B2   = 3'd4;
   localparam logic [2:0] ST_HOLD = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [1:0]  size_q, size_d;
   logic [7:0]  ir_opcode_q, ir_opcode_d;
   logic [7:0]  ir_op1_q, ir_op1_d;
   logic [7:0]  ir_op2_q, ir_op2_d;
   logic [15:0] ir_pc_q, ir_pc_d;
   logic [1:0]  dec_size_eff;

   // A decoder answer of 0 would otherwise stall the operand sequencing.
   assign dec_size_eff = (bus.dec_size == 2'd0) ? 2'd1 : bus.dec_size;

   // pc_q keeps the opcode address until the instruction is complete, then
   // advances by the size on entry to HOLD; operand addresses are offsets.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      size_d      = size_q;
      ir_opcode_d = ir_opcode_q;
      ir_op1_d    = ir_op1_q;
      ir_op2_d    = ir_op2_q;
      ir_pc_d     = ir_pc_q;

      case (state_q)
         ST_IDLE: state_d = ST_OPC;
         ST_OPC:  state_d = ST_DEC;
         ST_DEC: begin
            ir_opcode_d = bus.mem_rdata;
            ir_pc_d     = pc_q;
            size_d      = dec_size_eff;
            ir_op1_d    = 8'h00;
            ir_op2_d    = 8'h00;
            if (dec_size_eff == 2'd1) begin
               state_d = ST_HOLD;
               pc_d    = pc_q + 16'd1;
            end else begin
               state_d = ST_B1;
            end
         end
         ST_B1: begin
            ir_op1_d = bus.mem_rdata;
            if (size_q == 2'd3) begin
               state_d = ST_B2;
            end else begin
               state_d = ST_HOLD;
               pc_d    = pc_q + 16'd2;
            end
         end
         ST_B2: begin
            ir_op2_d = bus.mem_rdata;
            state_d  = ST_HOLD;
            pc_d     = pc_q + 16'd3;
         end
         ST_HOLD: begin
            if (bus.ir_ready) begin
               state_d = ST_OPC;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Redirect wins everywhere; a partially assembled instruction is
      // dropped simply by never reaching HOLD.
      if (bus.redirect_valid) begin
         state_d = ST_OPC;
         pc_d    = bus.redirect_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         size_q      <= 2'd1;
         ir_opcode_q <= 8'h00;
         ir_op1_q    <= 8'h00;
         ir_op2_q    <= 8'h00;
         ir_pc_q     <= 16'h0000;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         size_q      <= size_d;
         ir_opcode_q <= ir_opcode_d;
         ir_op1_q    <= ir_op1_d;
         ir_op2_q    <= ir_op2_d;
         ir_pc_q     <= ir_pc_d;
      end
   end

   // Strobes are issued one state ahead of the state that consumes the data.
   always_comb begin
      bus.mem_rd   = 1'b0;
      bus.mem_addr = 16'h0000;
      case (state_q)
         ST_OPC: begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = pc_q;
         end
         ST_DEC: begin
            if (dec_size_eff != 2'd1) begin
               bus.mem_rd   = 1'b1;
               bus.mem_addr = pc_q + 16'd1;
            end
         end
         ST_B1: begin
            if (size_q == 2'd3) begin
               bus.mem_rd   = 1'b1;
               bus.mem_addr = pc_q + 16'd2;
            end
         end
         default: begin
            bus.mem_rd   = 1'b0;
            bus.mem_addr = 16'h0000;
         end
      endcase
   end

   // The decoder sees the live memory byte only while it is being sized.
   assign bus.dec_opcode = (state_q == ST_DEC) ? bus.mem_rdata : ir_opcode_q;
   assign bus.ir_valid   = (state_q == ST_HOLD);
   assign bus.ir_opcode  = ir_opcode_q;
   assign bus.ir_op1     = ir_op1_q;
   assign bus.ir_op2     = ir_op2_q;
   assign bus.ir_pc      = ir_pc_q;

`ifdef FETCH_COUNT_EN
   logic        accept;
   logic [15:0] count_q;

   assign accept = (state_q == ST_HOLD) && bus.ir_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 16'h0000;
      end else if (accept) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign bus.instr_count = count_q;
`else
   assign bus.instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   typedef struct packed {
      logic [7:0]  opc;
      logic [7:0]  op1;
      logic [7:0]  op2;
      logic [15:0] pc;
   } instr_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(16'h0200)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [7:0]  mem [0:65535];
   instr_t      exp_q[$];
   logic [15:0] strobe_q[$];
   int          checks = 0;
   int          errors = 0;
   instr_t      mon_got;
   instr_t      mon_want;

`ifdef FETCH_COUNT_EN
   localparam logic [15:0] EXP_COUNT3 = 16'd3;
`else
   localparam logic [15:0] EXP_COUNT3 = 16'd0;
`endif

   function automatic logic [1:0] size_of(input logic [7:0] op);
      case (op)
         8'h4C:   return 2'd3;
         8'hA9:   return 2'd2;
         8'h00:   return 2'd0;
         default: return 2'd1;
      endcase
   endfunction

   assign bus.dec_size = size_of(bus.dec_opcode);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.mem_rdata <= 8'h00;
      else if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Monitor: log strobes, score accepted instructions against exp_q.
   always @(negedge clk) begin
      #3;
      if (rst_n === 1'b1) begin
         if (bus.mem_rd === 1'b1) strobe_q.push_back(bus.mem_addr);
         if (bus.ir_valid === 1'b1) begin
            checks++;
            if (bus.mem_rd !== 1'b0) begin
               errors++;
               $display("FAIL hold_no_strobe: got %b, required 0", bus.mem_rd);
            end
         end
         if (bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
            mon_got = {bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL accept_unexpected: got %h, required none", mon_got);
            end else begin
               mon_want = exp_q.pop_front();
               if (mon_got !== mon_want) begin
                  errors++;
                  $display("FAIL accept_instr: got %h, required %h", mon_got, mon_want);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reset, release and redirect so that the returned cycle is OPC at a.
   task automatic start_at(input logic [15:0] a);
      tick();
      rst_n = 1'b0;
      bus.ir_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = a;
      tick();
      bus.redirect_valid = 1'b0;
      strobe_q.delete();
   endtask

   task automatic test_reset();
      tick();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.mem_rd, bus.mem_addr, bus.ir_valid, bus.ir_opcode, bus.ir_op1,
           bus.ir_op2, bus.ir_pc, bus.instr_count} !== 74'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b addr=%h v=%b opc=%h op1=%h op2=%h pc=%h cnt=%h, required all 0",
                  bus.mem_rd, bus.mem_addr, bus.ir_valid, bus.ir_opcode, bus.ir_op1,
                  bus.ir_op2, bus.ir_pc, bus.instr_count);
      end
   endtask

   task automatic test_reset_release();
      int s_cyc;
      int v_cyc;
      mem[16'h0200] = 8'hE8;
      mem[16'h0201] = 8'hEA;
      bus.ir_ready = 1'b1;
      exp_q.push_back('{8'hE8, 8'h00, 8'h00, 16'h0200});
      s_cyc = 0;
      v_cyc = 0;
      rst_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (s_cyc == 0 && bus.mem_rd === 1'b1) begin
            s_cyc = i;
            checks++;
            if (bus.mem_addr !== 16'h0200) begin
               errors++;
               $display("FAIL first_strobe_addr: got %h, required 0200", bus.mem_addr);
            end
         end
         if (bus.ir_valid === 1'b1) begin
            v_cyc = i;
            break;
         end
      end
      checks++;
      if (s_cyc != 1) begin
         errors++;
         $display("FAIL first_strobe_cycle: got %0d, required 1", s_cyc);
      end
      checks++;
      if (v_cyc - s_cyc != 2) begin
         errors++;
         $display("FAIL latency_1byte: got %0d, required 2", v_cyc - s_cyc);
      end
      checks++;
      if ({bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc} !== {8'hE8, 8'h00, 8'h00, 16'h0200}) begin
         errors++;
         $display("FAIL release_instr: got %h %h %h %h, required e8 00 00 0200",
                  bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc);
      end
      tick();
      bus.ir_ready = 1'b0;
      checks++;
      if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0201}) begin
         errors++;
         $display("FAIL release_next_strobe: got rd=%b addr=%h, required rd=1 addr=0201",
                  bus.mem_rd, bus.mem_addr);
      end
   endtask

   task automatic test_three_byte();
      int c;
      mem[16'h0010] = 8'h4C;
      mem[16'h0011] = 8'h34;
      mem[16'h0012] = 8'h12;
      mem[16'h0013] = 8'hEA;
      start_at(16'h0010);
      exp_q.push_back('{8'h4C, 8'h34, 8'h12, 16'h0010});
      c = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.ir_valid === 1'b1) begin
            c = i;
            break;
         end
      end
      checks++;
      if (c != 4) begin
         errors++;
         $display("FAIL latency_3byte: got %0d, required 4", c);
      end
      checks++;
      if (strobe_q.size() != 3 || strobe_q[0] !== 16'h0010 || strobe_q[1] !== 16'h0011 ||
          strobe_q[2] !== 16'h0012) begin
         errors++;
         $display("FAIL strobes_3byte: got %p, required 0010 0011 0012", strobe_q);
      end
      checks++;
      if ({bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc} !== {8'h4C, 8'h34, 8'h12, 16'h0010}) begin
         errors++;
         $display("FAIL instr_3byte: got %h %h %h %h, required 4c 34 12 0010",
                  bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc);
      end
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      checks++;
      if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0013}) begin
         errors++;
         $display("FAIL next_pc_3byte: got rd=%b addr=%h, required rd=1 addr=0013",
                  bus.mem_rd, bus.mem_addr);
      end
   endtask

   task automatic test_hold_stall();
      int c;
      mem[16'h0100] = 8'hA9;
      mem[16'h0101] = 8'h55;
      mem[16'h0102] = 8'hEA;
      start_at(16'h0100);
      exp_q.push_back('{8'hA9, 8'h55, 8'h00, 16'h0100});
      c = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.ir_valid === 1'b1) begin
            c = i;
            break;
         end
      end
      checks++;
      if (c != 3) begin
         errors++;
         $display("FAIL latency_2byte: got %0d, required 3", c);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({bus.ir_valid, bus.mem_rd, bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc} !==
             {1'b1, 1'b0, 8'hA9, 8'h55, 8'h00, 16'h0100}) begin
            errors++;
            $display("FAIL stall_stable: got v=%b rd=%b %h %h %h %h, required v=1 rd=0 a9 55 00 0100",
                     bus.ir_valid, bus.mem_rd, bus.ir_opcode, bus.ir_op1, bus.ir_op2, bus.ir_pc);
         end
      end
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
      checks++;
      if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0102}) begin
         errors++;
         $display("FAIL stall_release: got rd=%b addr=%h, required rd=1 addr=0102",
                  bus.mem_rd, bus.mem_addr);
      end
   endtask

   task automatic test_redirect_b1();
      int c;
      mem[16'h0300] = 8'hA9;
      mem[16'h0301] = 8'h77;
      mem[16'h0400] = 8'hE8;
      start_at(16'h0300);
      bus.ir_ready = 1'b1;
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0400;
      tick();
      bus.redirect_valid = 1'b0;
      bus.ir_ready = 1'b0;
      checks++;
      if ({bus.ir_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 16'h0400}) begin
         errors++;
         $display("FAIL redirect_b1: got v=%b rd=%b addr=%h, required v=0 rd=1 addr=0400",
                  bus.ir_valid, bus.mem_rd, bus.mem_addr);
      end
      exp_q.push_back('{8'hE8, 8'h00, 8'h00, 16'h0400});
      c = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.ir_valid === 1'b1) begin
            c = i;
            break;
         end
      end
      checks++;
      if (c != 2 || bus.ir_pc !== 16'h0400) begin
         errors++;
         $display("FAIL redirect_target: got lat=%0d pc=%h, required lat=2 pc=0400", c, bus.ir_pc);
      end
      bus.ir_ready = 1'b1;
      tick();
      bus.ir_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] want_s [6];
      want_s = '{16'h0500, 16'h0501, 16'h0502, 16'h0503, 16'h0504, 16'h0505};
      mem[16'h0500] = 8'h00;
      mem[16'h0501] = 8'hA9;
      mem[16'h0502] = 8'h66;
      mem[16'h0503] = 8'h4C;
      mem[16'h0504] = 8'h01;
      mem[16'h0505] = 8'h02;
      mem[16'h0506] = 8'hEA;
      start_at(16'h0500);
      bus.ir_ready = 1'b1;
      exp_q.push_back('{8'h00, 8'h00, 8'h00, 16'h0500});
      exp_q.push_back('{8'hA9, 8'h66, 8'h00, 16'h0501});
      exp_q.push_back('{8'h4C, 8'h01, 8'h02, 16'h0503});
      for (int i = 0; i < 12; i++) tick();
      bus.ir_ready = 1'b0;
      checks++;
      if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0506}) begin
         errors++;
         $display("FAIL b2b_next: got rd=%b addr=%h, required rd=1 addr=0506",
                  bus.mem_rd, bus.mem_addr);
      end
      checks++;
      if (strobe_q.size() != 6) begin
         errors++;
         $display("FAIL b2b_strobe_count: got %0d, required 6", strobe_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (strobe_q[i] !== want_s[i]) begin
               errors++;
               $display("FAIL b2b_strobe_%0d: got %h, required %h", i, strobe_q[i], want_s[i]);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drained: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_wrap_count();
      mem[16'hFFFF] = 8'hE8;
      mem[16'h0000] = 8'hEA;
      mem[16'h0001] = 8'hC8;
      start_at(16'hFFFF);
      bus.ir_ready = 1'b1;
      exp_q.push_back('{8'hE8, 8'h00, 8'h00, 16'hFFFF});
      exp_q.push_back('{8'hEA, 8'h00, 8'h00, 16'h0000});
      exp_q.push_back('{8'hC8, 8'h00, 8'h00, 16'h0001});
      tick();
      tick();
      checks++;
      if ({bus.ir_valid, bus.ir_pc} !== {1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL wrap_ir_pc: got v=%b pc=%h, required v=1 pc=ffff", bus.ir_valid, bus.ir_pc);
      end
      tick();
      checks++;
      if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_strobe: got rd=%b addr=%h, required rd=1 addr=0000",
                  bus.mem_rd, bus.mem_addr);
      end
      for (int i = 0; i < 5; i++) tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h0600;
      tick();
      bus.redirect_valid = 1'b0;
      bus.ir_ready = 1'b0;
      checks++;
      if ({bus.ir_valid, bus.mem_rd, bus.mem_addr} !== {1'b0, 1'b1, 16'h0600}) begin
         errors++;
         $display("FAIL hold_redirect: got v=%b rd=%b addr=%h, required v=0 rd=1 addr=0600",
                  bus.ir_valid, bus.mem_rd, bus.mem_addr);
      end
      checks++;
      if (bus.instr_count !== EXP_COUNT3) begin
         errors++;
         $display("FAIL instr_count: got %0d, required %0d", bus.instr_count, EXP_COUNT3);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_drained: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      mem[16'h0010] = 8'h4C;
      mem[16'h0200] = 8'hE8;
      start_at(16'h0010);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_rd, bus.mem_addr, bus.ir_valid, bus.ir_opcode, bus.ir_pc} !== 42'd0) begin
         errors++;
         $display("FAIL async_abort: got rd=%b addr=%h v=%b opc=%h pc=%h, required all 0",
                  bus.mem_rd, bus.mem_addr, bus.ir_valid, bus.ir_opcode, bus.ir_pc);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0200}) begin
         errors++;
         $display("FAIL restart_strobe: got rd=%b addr=%h, required rd=1 addr=0200",
                  bus.mem_rd, bus.mem_addr);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.ir_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;

      test_reset();
      test_reset_release();
      test_three_byte();
      test_hold_stall();
      test_redirect_b1();
      test_back_to_back();
      test_wrap_count();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
